// File: rtl/cpu_controller.sv
// Eight-phase instruction sequencer for the basic 8-bit CPU.
// Steps through one instruction every 8 clocks and decodes fetch, ALU, store and PC strobes.
module cpu_controller (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] opcode,
    input  logic       zero,
    output logic       mem_rd,
    output logic       load_ir,
    output logic       halt,
    output logic       inc_pc,
    output logic       load_ac,
    output logic       load_pc,
    output logic       mem_wr,
    output logic       data_e,
    output logic [2:0] phase
);

    localparam logic [2:0] OP_HLT = 3'd0;
    localparam logic [2:0] OP_SKZ = 3'd1;
    localparam logic [2:0] OP_ADD = 3'd2;
    localparam logic [2:0] OP_AND = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;
    localparam logic [2:0] OP_LDA = 3'd5;
    localparam logic [2:0] OP_STO = 3'd6;
    localparam logic [2:0] OP_JMP = 3'd7;

    typedef enum logic [2:0] {
        INST_ADDR  = 3'd0,
        INST_FETCH = 3'd1,
        INST_LOAD  = 3'd2,
        IDLE       = 3'd3,
        OP_ADDR    = 3'd4,
        OP_FETCH   = 3'd5,
        ALU_OP     = 3'd6,
        STORE      = 3'd7
    } phase_e;

    phase_e phase_q;
    logic   halted_q;
    logic   aluop;

    // Phase counter; HLT freezes it at OP_ADDR until reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            phase_q  <= INST_ADDR;
            halted_q <= 1'b0;
        end else if (!halted_q) begin
            if (phase_q == OP_ADDR && opcode == OP_HLT) begin
                halted_q <= 1'b1;
            end else begin
                phase_q <= phase_e'(3'(phase_q + 3'd1));
            end
        end
    end

    assign aluop = (opcode == OP_ADD) || (opcode == OP_AND) ||
                   (opcode == OP_XOR) || (opcode == OP_LDA);
    assign phase = phase_q;

    // Strobe decode from phase, opcode and zero flag.
    always_comb begin
        mem_rd  = 1'b0;
        load_ir = 1'b0;
        halt    = 1'b0;
        inc_pc  = 1'b0;
        load_ac = 1'b0;
        load_pc = 1'b0;
        mem_wr  = 1'b0;
        data_e  = 1'b0;
        if (halted_q) begin
            halt = 1'b1;
        end else begin
            case (phase_q)
                INST_ADDR: ;
                INST_FETCH: mem_rd = 1'b1;
                INST_LOAD, IDLE: begin
                    mem_rd  = 1'b1;
                    load_ir = 1'b1;
                end
                OP_ADDR: begin
                    halt   = (opcode == OP_HLT);
                    inc_pc = (opcode != OP_HLT);
                end
                OP_FETCH: mem_rd = aluop;
                ALU_OP: begin
                    mem_rd  = aluop;
                    load_ac = aluop;
                    inc_pc  = (opcode == OP_SKZ) && zero;
                    load_pc = (opcode == OP_JMP);
                    data_e  = (opcode == OP_STO);
                end
                STORE: begin
                    mem_rd  = aluop;
                    load_ac = aluop;
                    inc_pc  = (opcode == OP_JMP);
                    load_pc = (opcode == OP_JMP);
                    mem_wr  = (opcode == OP_STO);
                    data_e  = (opcode == OP_STO);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_controller.sv
// Bench for cpu_controller: directed instruction sequences plus random traffic
// compared each cycle against a cycle-counting reference model.
module tb_cpu_controller;

    localparam logic [2:0] HLT = 3'd0;
    localparam logic [2:0] SKZ = 3'd1;
    localparam logic [2:0] ADD = 3'd2;
    localparam logic [2:0] STO = 3'd6;
    localparam logic [2:0] LDA = 3'd5;
    localparam logic [2:0] JMP = 3'd7;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] opcode = 3'd0;
    logic       zero = 1'b0;
    logic       mem_rd, load_ir, halt, inc_pc, load_ac, load_pc, mem_wr, data_e;
    logic [2:0] phase;

    int errors = 0;
    int checks = 0;
    int m_phase = 0;
    bit m_halted = 1'b0;
    int inc_cnt = 0;

    cpu_controller dut (
        .clk(clk), .rst(rst), .opcode(opcode), .zero(zero),
        .mem_rd(mem_rd), .load_ir(load_ir), .halt(halt), .inc_pc(inc_pc),
        .load_ac(load_ac), .load_pc(load_pc), .mem_wr(mem_wr), .data_e(data_e),
        .phase(phase)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %02h expected %02h (model phase %0d halted %0d op %0d zero %0d)",
                     tag, got, exp, m_phase, m_halted, opcode, zero);
        end
    endtask

    // Expected strobes {mem_rd,load_ir,halt,inc_pc,load_ac,load_pc,mem_wr,data_e}.
    function automatic logic [7:0] expect_strobes(int p, bit h, logic [2:0] op, logic z);
        bit alu;
        bit e_rd, e_ir, e_ht, e_inc, e_ac, e_pc, e_wr, e_de;
        alu   = (op == 3'd2) || (op == 3'd3) || (op == 3'd4) || (op == 3'd5);
        e_ht  = h || (p == 4 && op == HLT);
        e_rd  = !h && ((p >= 1 && p <= 3) || (p >= 5 && alu));
        e_ir  = !h && (p == 2 || p == 3);
        e_inc = !h && ((p == 4 && op != HLT) || (p == 6 && op == SKZ && z == 1'b1)
                       || (p == 7 && op == JMP));
        e_ac  = !h && p >= 6 && alu;
        e_pc  = !h && p >= 6 && op == JMP;
        e_wr  = !h && p == 7 && op == STO;
        e_de  = !h && p >= 6 && op == STO;
        return {e_rd, e_ir, e_ht, e_inc, e_ac, e_pc, e_wr, e_de};
    endfunction

    task automatic run_cycle(input logic r, input logic [2:0] op, input logic z, input bit chk);
        rst    = r;
        opcode = op;
        zero   = z;
        @(negedge clk);
        if (chk) begin
            check_eq("phase", 8'(phase), 8'(m_phase));
            check_eq("strobes",
                     {mem_rd, load_ir, halt, inc_pc, load_ac, load_pc, mem_wr, data_e},
                     expect_strobes(m_phase, m_halted, op, z));
        end
        if (inc_pc === 1'b1) inc_cnt++;
        @(posedge clk);
        if (r) begin
            m_phase  = 0;
            m_halted = 1'b0;
        end else if (!m_halted) begin
            if (m_phase == 4 && op == HLT) m_halted = 1'b1;
            else m_phase = (m_phase + 1) % 8;
        end
        #1;
    endtask

    initial begin
        run_cycle(1'b1, ADD, 1'b0, 1'b0);
        check_eq("reset_phase", 8'(phase), 8'd0);
        check_eq("reset_halt", 8'(halt), 8'd0);

        for (int i = 0; i < 16; i++) run_cycle(1'b0, ADD, 1'(i % 2), 1'b1);
        for (int i = 0; i < 8; i++) run_cycle(1'b0, STO, 1'b0, 1'b1);

        inc_cnt = 0;
        for (int i = 0; i < 8; i++) run_cycle(1'b0, SKZ, 1'b1, 1'b1);
        check_eq("skz_z1_inc_pulses", 8'(inc_cnt), 8'd2);
        inc_cnt = 0;
        for (int i = 0; i < 8; i++) run_cycle(1'b0, SKZ, 1'b0, 1'b1);
        check_eq("skz_z0_inc_pulses", 8'(inc_cnt), 8'd1);
        inc_cnt = 0;
        for (int i = 0; i < 8; i++) run_cycle(1'b0, JMP, 1'b0, 1'b1);
        check_eq("jmp_inc_pulses", 8'(inc_cnt), 8'd2);

        // Halt, stay frozen with changing inputs, then recover via reset.
        for (int i = 0; i < 5; i++) run_cycle(1'b0, HLT, 1'b0, 1'b1);
        for (int i = 0; i < 20; i++) run_cycle(1'b0, ADD, 1'($urandom_range(0, 1)), 1'b1);
        check_eq("halted_phase", 8'(phase), 8'd4);
        run_cycle(1'b1, ADD, 1'b0, 1'b1);
        check_eq("post_halt_phase", 8'(phase), 8'd0);
        check_eq("post_halt_halt", 8'(halt), 8'd0);
        for (int i = 0; i < 8; i++) run_cycle(1'b0, ADD, 1'b0, 1'b1);

        // Reset in ALU_OP aborts the LDA.
        for (int i = 0; i < 6; i++) run_cycle(1'b0, LDA, 1'b0, 1'b1);
        check_eq("pre_abort_phase", 8'(phase), 8'd6);
        run_cycle(1'b1, LDA, 1'b0, 1'b1);
        check_eq("abort_phase", 8'(phase), 8'd0);
        check_eq("abort_load_ac", 8'(load_ac), 8'd0);
        check_eq("abort_mem_rd", 8'(mem_rd), 8'd0);
        for (int i = 0; i < 8; i++) run_cycle(1'b0, LDA, 1'b0, 1'b1);

        for (int i = 0; i < 600; i++) begin
            run_cycle(1'($urandom_range(0, 39) == 0), 3'($urandom_range(0, 7)),
                      1'($urandom_range(0, 1)), 1'b1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cpu_controller.md
Name: cpu_controller

Overview:
- Eight-phase instruction sequencer for the basic 8-bit CPU.
- Sits directly upstream of the ALU and accumulator.
- Consumes the instruction-register opcode (opcode_t from typedefs) and the ALU zero flag.
- Generates the strobes that fetch instructions and operands, load the accumulator, store to memory, and steer the program counter.

Parameters:
- None. Opcode encoding comes from typedefs::opcode_t: HLT=0, SKZ=1, ADD=2, AND=3, XOR=4, LDA=5, STO=6, JMP=7.

Ports:
- clk  input  1  single clock; all state updates on posedge.
- rst  input  1  synchronous, active-high reset.
- opcode  input  opcode_t (3)  current instruction opcode from the instruction register.
- zero  input  1  ALU zero flag (accumulator == 0).
- mem_rd  output  1  memory read enable.
- load_ir  output  1  load instruction register from memory data.
- halt  output  1  processor halted.
- inc_pc  output  1  increment program counter.
- load_ac  output  1  load accumulator from ALU out.
- load_pc  output  1  load program counter from IR operand address.
- mem_wr  output  1  memory write strobe.
- data_e  output  1  drive accumulator onto data bus.
- phase  output  3  current phase, for debug and bench.

Behaviour:
- Phase register, 3 bits. Encoding and order: INST_ADDR=0, INST_FETCH=1, INST_LOAD=2, IDLE=3, OP_ADDR=4, OP_FETCH=5, ALU_OP=6, STORE=7.
- Phase advances by exactly one every posedge clk. STORE wraps to INST_ADDR. One instruction takes 8 cycles.
- Reset: on a posedge with rst=1, phase <= INST_ADDR and halted <= 0, regardless of current phase (reset mid-instruction aborts it).
- All outputs are combinational decodes of phase, halted, opcode and zero. In INST_ADDR every output is 0 except phase. So after reset every strobe is 0 and phase=0.
- ALUOP = opcode in {ADD, AND, XOR, LDA}.
- Per-phase outputs (anything not listed is 0):
  - INST_ADDR: none.
  - INST_FETCH: mem_rd=1.
  - INST_LOAD: mem_rd=1, load_ir=1.
  - IDLE: mem_rd=1, load_ir=1.
  - OP_ADDR: if opcode==HLT then halt=1, else inc_pc=1.
  - OP_FETCH: mem_rd=ALUOP.
  - ALU_OP: mem_rd=ALUOP, load_ac=ALUOP, inc_pc=(opcode==SKZ && zero), load_pc=(opcode==JMP), data_e=(opcode==STO).
  - STORE: mem_rd=ALUOP, load_ac=ALUOP, inc_pc=(opcode==JMP), load_pc=(opcode==JMP), mem_wr=(opcode==STO), data_e=(opcode==STO).
- Halt handling:
  - At the posedge ending OP_ADDR with opcode==HLT, halted <= 1 and phase holds at OP_ADDR.
  - While halted: phase frozen at 4, halt=1, all other strobes 0, opcode and zero ignored.
  - Only rst exits halt.
- SKZ with zero=0 produces no PC action. SKZ with zero=1 gives exactly one extra inc_pc pulse, in ALU_OP.
- Opcode and zero are sampled combinationally each cycle. The design relies on the IR being stable from IDLE onward. The controller does not latch them.
- Out-of-range opcode values cannot occur (3-bit enum). No default-state recovery is needed beyond the wrap.

Test Plan:
- Reset, then hold rst=0 for 16 cycles with opcode=ADD.
  - phase sequence 0..7,0..7.
  - mem_rd high in phases 1,2,3,5,6,7; load_ir in 2,3; inc_pc in 4; load_ac in 6,7.
  - mem_wr, load_pc, halt never asserted.
- opcode=STO for one instruction: mem_wr=1 only in phase 7, data_e=1 in phases 6 and 7, load_ac=0 and mem_rd=0 in phases 5-7.
- opcode=SKZ:
  - with zero=1, inc_pc pulses in phases 4 and 6 (2 pulses per instruction).
  - with zero=0, inc_pc pulses in phase 4 only.
- opcode=JMP: load_pc=1 in phases 6 and 7, inc_pc=1 in phases 4 and 7, mem_rd=0 in phases 5-7.
- opcode=HLT:
  - phase reaches 4, halt=1 and phase stays 4 for 20 further cycles with all strobes 0, even after opcode changes to ADD.
  - Then assert rst one cycle: phase=0, halt=0, normal sequencing resumes.
- Assert rst during phase 6 with opcode=LDA: the next cycle shows phase=0, load_ac=0 and mem_rd=0, then a normal 8-cycle sequence follows.
